// File: rtl/integ_accum.sv
`default_nettype none
// ============================================================================
//  Module   : integ_accum
//  Brief    : Integrate-and-dump decimator. Sums rate+1 strobed samples per
//             window and emits the full-precision window sum with a
//             one-cycle strobe for a downstream bit-gain shifter.
//  Revision : 1.0  initial release
// ============================================================================
module integ_accum #(
    parameter int bw         = 16,
    parameter int maxbitgain = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [7:0]                     rate,
    input  logic                           strobe_in,
    input  logic signed [bw-1:0]           signal_in,
    output logic                           strobe_out,
    output logic signed [bw+maxbitgain-1:0] integ_out
);

    localparam int c_OW = bw + maxbitgain;

    // Window position, latched window length, running sum and output regs
    logic [7:0]             r_cnt;
    logic [7:0]             r_rate;
    logic signed [c_OW-1:0] r_acc;
    logic signed [c_OW-1:0] r_integ;
    logic                   r_strobe;

    // Sign-extended sample; the growth bits make the sum exact for 256 samples
    logic signed [c_OW-1:0] w_sext;
    logic signed [c_OW-1:0] w_sum;

    // Sample widening and the running-sum adder
    always_comb begin
        w_sext = {{maxbitgain{signal_in[bw-1]}}, signal_in};
        w_sum  = r_acc + w_sext;
    end

    // Integrate-and-dump state; rate is only sampled at a window start so a
    // mid-window change cannot alter the length of the window in progress
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= 8'd0;
            r_rate   <= 8'd0;
            r_acc    <= '0;
            r_integ  <= '0;
            r_strobe <= 1'b0;
        end else if (!enable) begin
            // Idle: drop any partial window and present a zero output
            r_cnt    <= 8'd0;
            r_acc    <= '0;
            r_integ  <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (strobe_in) begin
                if (r_cnt == 8'd0) begin
                    r_rate <= rate;
                    r_acc  <= w_sext;
                    if (rate == 8'd0) begin
                        // Single-sample window: dump the sample directly
                        r_integ  <= w_sext;
                        r_strobe <= 1'b1;
                    end else begin
                        r_cnt <= 8'd1;
                    end
                end else if (r_cnt == r_rate) begin
                    // Final sample of the window
                    r_integ  <= w_sum;
                    r_strobe <= 1'b1;
                    r_cnt    <= 8'd0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign strobe_out = r_strobe;
    assign integ_out  = r_integ;

endmodule
`default_nettype wire

// File: tb/tb_integ_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_integ_accum
//  Brief    : Directed self-checking bench for integ_accum (bw=16, gain=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_integ_accum;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic [7:0]         rate;
    logic               strobe_in;
    logic signed [15:0] signal_in;
    logic               strobe_out;
    logic signed [23:0] integ_out;

    int n_pass = 0;
    int n_fail = 0;

    integ_accum #(.bw(16), .maxbitgain(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .rate       (rate),
        .strobe_in  (strobe_in),
        .signal_in  (signal_in),
        .strobe_out (strobe_out),
        .integ_out  (integ_out)
    );

    always #5 clock = ~clock;

    // Apply inputs, let one rising edge pass, return at the falling edge
    task automatic cyc(input logic s, input logic signed [15:0] v);
        strobe_in = s;
        signal_in = v;
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic so, input logic [23:0] val);
        chk({tag, ".strobe"}, {23'd0, strobe_out}, {23'd0, so});
        chk({tag, ".integ"}, integ_out, val);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; rate = 8'd0; strobe_in = 1'b0; signal_in = '0;
        @(negedge clock);
        cyc(1'b1, 16'sd99);
        chk_out("reset", 1'b0, 24'h000000);
        reset = 1'b0; enable = 1'b1;

        // rate=3, back-to-back 1,2,3,4 -> 10
        rate = 8'd3;
        cyc(1'b1, 16'sd1); chk_out("r3.s1", 1'b0, 24'h000000);
        cyc(1'b1, 16'sd2); chk_out("r3.s2", 1'b0, 24'h000000);
        cyc(1'b1, 16'sd3); chk_out("r3.s3", 1'b0, 24'h000000);
        cyc(1'b1, 16'sd4); chk_out("r3.dump", 1'b1, 24'h00000A);
        cyc(1'b0, 16'sd0); chk_out("r3.hold", 1'b0, 24'h00000A);

        // rate=255, extremes
        rate = 8'd255;
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, -16'sd32768);
            if (i == 254) chk_out("r255.neg.pre", 1'b0, 24'h00000A);
        end
        chk_out("r255.neg", 1'b1, 24'h800000);
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 16'sd32767);
            if (i == 254) chk_out("r255.pos.pre", 1'b0, 24'h800000);
        end
        chk_out("r255.pos", 1'b1, 24'h7FFF00);
        cyc(1'b0, 16'sd0); chk_out("r255.hold", 1'b0, 24'h7FFF00);

        // rate=0: dump every sample
        rate = 8'd0;
        cyc(1'b1, -16'sd5); chk_out("r0.a", 1'b1, 24'hFFFFFB);
        cyc(1'b1, 16'sd7);  chk_out("r0.b", 1'b1, 24'h000007);
        cyc(1'b0, 16'sd0);  chk_out("r0.idle", 1'b0, 24'h000007);

        // rate change mid-window: 4-sample window, then 2-sample windows
        rate = 8'd3;
        cyc(1'b1, 16'sd1);
        cyc(1'b1, 16'sd2);
        rate = 8'd1;
        cyc(1'b1, 16'sd3); chk_out("rc.s3", 1'b0, 24'h000007);
        cyc(1'b1, 16'sd4); chk_out("rc.d1", 1'b1, 24'h00000A);
        cyc(1'b1, 16'sd5); chk_out("rc.s5", 1'b0, 24'h00000A);
        cyc(1'b1, 16'sd6); chk_out("rc.d2", 1'b1, 24'h00000B);
        cyc(1'b1, 16'sd7); chk_out("rc.s7", 1'b0, 24'h00000B);
        cyc(1'b1, 16'sd8); chk_out("rc.d3", 1'b1, 24'h00000F);

        // enable drop discards partial window
        rate = 8'd3;
        cyc(1'b1, 16'sd100);
        cyc(1'b1, 16'sd100);
        enable = 1'b0;
        cyc(1'b1, 16'sd50); chk_out("en.low", 1'b0, 24'h000000);
        enable = 1'b1;
        cyc(1'b1, 16'sd1);
        cyc(1'b1, 16'sd1);
        cyc(1'b1, 16'sd1); chk_out("en.s3", 1'b0, 24'h000000);
        cyc(1'b1, 16'sd1); chk_out("en.dump", 1'b1, 24'h000004);

        // reset mid-window discards partial window
        cyc(1'b1, 16'sd100);
        cyc(1'b1, 16'sd100);
        reset = 1'b1;
        cyc(1'b1, 16'sd100); chk_out("rst.mid", 1'b0, 24'h000000);
        reset = 1'b0;
        cyc(1'b1, 16'sd1);
        cyc(1'b1, 16'sd1);
        cyc(1'b1, 16'sd1); chk_out("rst.s3", 1'b0, 24'h000000);
        cyc(1'b1, 16'sd1); chk_out("rst.dump", 1'b1, 24'h000004);

        // rate=2, gapped strobes every third cycle
        rate = 8'd2;
        cyc(1'b1, 16'sd10); chk_out("gap.a0", 1'b0, 24'h000004);
        cyc(1'b0, 16'sd0);  chk_out("gap.a1", 1'b0, 24'h000004);
        cyc(1'b0, 16'sd0);  chk_out("gap.a2", 1'b0, 24'h000004);
        cyc(1'b1, 16'sd20); chk_out("gap.b0", 1'b0, 24'h000004);
        cyc(1'b0, 16'sd0);  chk_out("gap.b1", 1'b0, 24'h000004);
        cyc(1'b0, 16'sd0);  chk_out("gap.b2", 1'b0, 24'h000004);
        cyc(1'b1, 16'sd30); chk_out("gap.dump", 1'b1, 24'h00003C);
        cyc(1'b0, 16'sd0);  chk_out("gap.c1", 1'b0, 24'h00003C);
        cyc(1'b0, 16'sd0);  chk_out("gap.c2", 1'b0, 24'h00003C);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
`default_nettype wire
